// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INST      = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries; clear beats push.
module if_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload needs no reset; only entries below count are ever presented.
    always_ff @(posedge clk_i) begin
        if (push && !clear) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests under a
// credit limit, queues returned words and drops wrong-path responses on redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2,
    parameter int          MAX_OUTST = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    if_fetch_unit_if.master         imem,
    output logic [31:0]             inst_o,
    output logic [31:0]             PC_o,
    output logic                    valid_o
);

    localparam int CW = $clog2(MAX_OUTST + BUF_DEPTH + 1);

    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;

    fetch_entry_t  q_head;
    fetch_entry_t  q_din;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;

    logic          pop;
    logic          push;
    logic          drop_resp;
    logic          credit_ok;
    logic          issue;
    logic          fire;

    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        drop_resp = 1'b0;
        credit_ok = 1'b0;
        issue     = 1'b0;
        fire      = 1'b0;

        pop       = !q_empty && !stall_i && !redirect_i;
        drop_resp = (drop_q != '0);
        push      = imem.imem_rvalid && !drop_resp && !redirect_i;
        // Live in-flight words plus queued words must fit the queue; a head
        // being consumed this cycle frees its slot for the next request.
        credit_ok = ((outst_q - drop_q) + q_count - CW'(pop)) < CW'(BUF_DEPTH);
        issue     = !rst_i && !redirect_i && (outst_q < CW'(MAX_OUTST)) && credit_ok;
        fire      = issue && imem.imem_gnt;
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = fetch_pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else if (redirect_i) begin
            // Everything still in flight, beyond a word landing right now, is wrong-path.
            fetch_pc_q <= word_align(redirect_pc_i);
            resp_pc_q  <= word_align(redirect_pc_i);
            outst_q    <= outst_q - CW'(imem.imem_rvalid);
            drop_q     <= outst_q - CW'(imem.imem_rvalid);
        end else begin
            if (fire) fetch_pc_q <= fetch_pc_q + PC_STEP;
            outst_q <= outst_q + CW'(fire) - CW'(imem.imem_rvalid);
            if (imem.imem_rvalid) begin
                if (drop_resp) drop_q    <= drop_q - 1'b1;
                else           resp_pc_q <= resp_pc_q + PC_STEP;
            end
        end
    end

    always_comb begin
        q_din      = '0;
        q_din.pc   = resp_pc_q;
        q_din.inst = imem.imem_rdata;
    end

    if_fetch_queue #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CW)
    ) u_queue (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .clear (redirect_i),
        .din   (q_din),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign valid_o = !q_empty;
    assign inst_o  = valid_o ? q_head.inst : BUBBLE_INST;
    assign PC_o    = valid_o ? q_head.pc   : 32'h0;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && q_full));

    a_no_stray_resp : assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem.imem_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order variable-latency imem model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic [31:0] inst_o;
    logic [31:0] PC_o;
    logic        valid_o;

    int vecs = 0;
    int errs = 0;

    if_fetch_unit_if bus();

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2),
        .MAX_OUTST (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus),
        .inst_o        (inst_o),
        .PC_o          (PC_o),
        .valid_o       (valid_o)
    );

    always #5 clk_i = ~clk_i;

    assign bus.imem_gnt = gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // imem model: grants recorded with a due cycle, answered strictly in order
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_addr.delete();
            q_due.delete();
            cyc = 0;
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= 32'h0;
        end else begin
            if (bus.imem_req && bus.imem_gnt) begin
                q_addr.push_back(bus.imem_addr);
                q_due.push_back(cyc + lat);
            end
            cyc = cyc + 1;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                bus.imem_rvalid <= 1'b0;
                bus.imem_rdata  <= 32'h0;
            end
        end
    end

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          gnt;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(bit s, bit r, logic [31:0] rpc, bit g,
                                bit req, logic [31:0] addr, bit v, logic [31:0] pc);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc; t.gnt = g;
        t.req = req; t.addr = addr; t.valid = v; t.pc = pc;
        return t;
    endfunction

    logic [97:0] obs;
    logic [97:0] exp;

    task automatic do_reset(input int latency);
        @(negedge clk_i);
        rst_i = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        gnt_en = 1'b1;
        lat = latency;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        vecs++;
        if (bus.imem_req !== 1'b0) begin
            $display("FAIL reset_req: got %b, expected 0", bus.imem_req);
            errs++;
        end
        vecs++;
        if ({valid_o, PC_o, inst_o} !== 65'h0) begin
            $display("FAIL reset_outputs: got valid=%b pc=%h inst=%h, expected all 0",
                     valid_o, PC_o, inst_o);
            errs++;
        end
    endtask

    task automatic test_stream();
        vec_t v[6];
        do_reset(1);
        v = '{mk(0,0,0,1, 1,32'h0, 0,0),
              mk(0,0,0,1, 1,32'h4, 0,0),
              mk(0,0,0,1, 1,32'h8, 1,32'h0),
              mk(0,0,0,1, 1,32'hC, 1,32'h4),
              mk(0,0,0,1, 1,32'h10,1,32'h8),
              mk(0,0,0,1, 1,32'h14,1,32'hC)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL stream cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_stall();
        vec_t v[10];
        do_reset(1);
        v = '{mk(0,0,0,1, 1,32'h0, 0,0),
              mk(0,0,0,1, 1,32'h4, 0,0),
              mk(0,0,0,1, 1,32'h8, 1,32'h0),
              mk(0,0,0,1, 1,32'hC, 1,32'h4),
              mk(1,0,0,1, 0,32'h0, 1,32'h8),
              mk(1,0,0,1, 0,32'h0, 1,32'h8),
              mk(1,0,0,1, 0,32'h0, 1,32'h8),
              mk(0,0,0,1, 1,32'h10,1,32'h8),
              mk(0,0,0,1, 1,32'h14,1,32'hC),
              mk(0,0,0,1, 1,32'h18,1,32'h10)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL stall cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
        stall_i = 1'b0;
    endtask

    task automatic test_redirect_drop();
        vec_t v[9];
        do_reset(3);
        v = '{mk(0,0,0,1,          1,32'h0,  0,0),
              mk(0,0,0,1,          1,32'h4,  0,0),
              mk(0,1,32'h100,1,    0,32'h0,  0,0),
              mk(0,0,0,1,          1,32'h100,0,0),
              mk(0,0,0,1,          1,32'h104,0,0),
              mk(0,0,0,1,          0,32'h0,  0,0),
              mk(0,0,0,1,          0,32'h0,  0,0),
              mk(0,0,0,1,          1,32'h108,1,32'h100),
              mk(0,0,0,1,          1,32'h10C,1,32'h104)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL redirect_drop cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_redirect_with_rvalid();
        vec_t v[6];
        do_reset(1);
        v = '{mk(0,0,0,1,        1,32'h0, 0,0),
              mk(0,1,32'h40,1,   0,32'h0, 0,0),
              mk(0,0,0,1,        1,32'h40,0,0),
              mk(0,0,0,1,        1,32'h44,0,0),
              mk(0,0,0,1,        1,32'h48,1,32'h40),
              mk(0,0,0,1,        1,32'h4C,1,32'h44)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL redirect_rvalid cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_no_grant();
        vec_t v[8];
        do_reset(1);
        v = '{mk(0,0,0,0,        1,32'h0,  0,0),
              mk(0,0,0,0,        1,32'h0,  0,0),
              mk(0,0,0,0,        1,32'h0,  0,0),
              mk(0,0,0,0,        1,32'h0,  0,0),
              mk(0,1,32'h203,0,  0,32'h0,  0,0),
              mk(0,0,0,1,        1,32'h200,0,0),
              mk(0,0,0,1,        1,32'h204,0,0),
              mk(0,0,0,1,        1,32'h208,1,32'h200)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL no_grant cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        vec_t v[5];
        do_reset(1);
        v = '{mk(0,1,32'hFFFF_FFFC,1, 0,32'h0,        0,0),
              mk(0,0,0,1,             1,32'hFFFF_FFFC,0,0),
              mk(0,0,0,1,             1,32'h0,        0,0),
              mk(0,0,0,1,             1,32'h4,        1,32'hFFFF_FFFC),
              mk(0,0,0,1,             1,32'h8,        1,32'h0)};
        foreach (v[i]) begin
            stall_i = v[i].stall; redirect_i = v[i].redir;
            redirect_pc_i = v[i].rpc; gnt_en = v[i].gnt;
            #1;
            obs = {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0, valid_o, PC_o, inst_o};
            exp = {v[i].req, v[i].req ? v[i].addr : 32'h0, v[i].valid,
                   v[i].valid ? v[i].pc : 32'h0, v[i].valid ? mem_word(v[i].pc) : 32'h0};
            vecs++;
            if (obs !== exp) begin
                $display("FAIL wrap cyc%0d: got %h, expected %h", i, obs, exp);
                errs++;
            end
            @(negedge clk_i);
        end
        redirect_i = 1'b0;
        // mid-fetch reset pulse: outputs must clear without waiting for a clock
        rst_i = 1'b1;
        #1;
        vecs++;
        if ({bus.imem_req, valid_o, PC_o, inst_o} !== 66'h0) begin
            $display("FAIL reset_pulse: got req=%b valid=%b pc=%h inst=%h, expected all 0",
                     bus.imem_req, valid_o, PC_o, inst_o);
            errs++;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL after_reset_c0: got req=%b addr=%h valid=%b, expected 1 00000000 0",
                     bus.imem_req, bus.imem_addr, valid_o);
            errs++;
        end
        @(negedge clk_i);
        #1;
        vecs++;
        if ({bus.imem_req, bus.imem_addr, valid_o} !== {1'b1, 32'h4, 1'b0}) begin
            $display("FAIL after_reset_c1: got req=%b addr=%h valid=%b, expected 1 00000004 0",
                     bus.imem_req, bus.imem_addr, valid_o);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_with_rvalid();
        test_no_grant();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
